// File: rtl/mouse_cursor_pkg.sv
// Shared constants for the mouse cursor overlay: the arrow sprite bitmap,
// the fixed sprite colours and the meaning of each 2-bit sprite code.
package mouse_cursor_pkg;

  // Sprite pixel codes
  localparam logic [1:0] TRANSP  = 2'd0;
  localparam logic [1:0] OUTLINE = 2'd1;
  localparam logic [1:0] FILL    = 2'd2;
  localparam logic [1:0] ACCENT  = 2'd3;

  // Fixed sprite colours in RGB332
  localparam logic [7:0] BLACK = 8'h00;
  localparam logic [7:0] WHITE = 8'hFF;

  // Arrow bitmap, row-major: SPRITE[row] holds 8 pixels, column c in bits [2c+1:2c].
  //   row0: 1 . . . . . . .
  //   row1: 1 1 . . . . . .
  //   row2: 1 2 1 . . . . .
  //   row3: 1 2 3 1 . . . .
  //   row4: 1 2 3 2 1 . . .
  //   row5: 1 2 2 1 1 1 . .
  //   row6: 1 1 2 1 . . . .
  //   row7: 1 . 1 2 1 . . .
  localparam logic [7:0][15:0] SPRITE = {
    16'h0191,  // row 7
    16'h0065,  // row 6
    16'h0569,  // row 5
    16'h01B9,  // row 4
    16'h0079,  // row 3
    16'h0019,  // row 2
    16'h0005,  // row 1
    16'h0001   // row 0
  };

endpackage

// File: rtl/cursor_sprite_rom.sv
// Combinational lookup of one 2-bit sprite code from a {row, column} address.
module cursor_sprite_rom
  import mouse_cursor_pkg::*;
(
  input  logic [5:0] addr,
  output logic [1:0] code
);

  logic [15:0] row_bits;

  // Pick the row by the upper address bits, then the 2-bit field by the column
  always_comb begin
    row_bits = SPRITE[addr[5:3]];
    code     = row_bits[{addr[2:0], 1'b0} +: 2];
  end

endmodule

// File: rtl/mouse_cursor_overlay.sv
// Overlays an 8x8 arrow cursor on the pixel stream at the mouse position,
// with frame-synchronous position updates and button click pulse outputs.
module mouse_cursor_overlay
  import mouse_cursor_pkg::*;
#(
  parameter int                 PIX_W       = 10,
  parameter int                 COLOR_W     = 8,
  parameter logic [COLOR_W-1:0] CLICK_COLOR = 8'hE0,
  parameter logic [COLOR_W-1:0] IDLE_COLOR  = 8'h1C,
  parameter int                 RST_X       = 268,
  parameter int                 RST_Y       = 201
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        mouse_x,
  input  logic [15:0]        mouse_y,
  input  logic [15:0]        mouse_status,
  input  logic               mouse_dav,
  input  logic               cursor_en,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_x,
  input  logic [PIX_W-1:0]   pix_y,
  input  logic [COLOR_W-1:0] bg_rgb,
  output logic               out_valid,
  output logic [COLOR_W-1:0] out_rgb,
  output logic               click_l,
  output logic               click_r
);

  logic [PIX_W-1:0]   shadow_x, shadow_y, active_x, active_y;
  logic [2:0]         shadow_btn, active_btn;
  logic [1:0]         prev_btn;
  logic [PIX_W:0]     dx_full, dy_full;
  logic               hit;
  logic               s1_valid, s1_hit;
  logic [2:0]         s1_dx, s1_dy;
  logic [COLOR_W-1:0] s1_bg, pix_color;
  logic [1:0]         code;
  logic               unused_bits;

  assign unused_bits = ^{mouse_x[15:PIX_W], mouse_y[15:PIX_W], mouse_status[15:3],
                         active_btn[2:1]};

  // Capture new mouse data into the shadow; promote to active only at frame start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_x   <= PIX_W'(RST_X);
      shadow_y   <= PIX_W'(RST_Y);
      active_x   <= PIX_W'(RST_X);
      active_y   <= PIX_W'(RST_Y);
      shadow_btn <= '0;
      active_btn <= '0;
    end else begin
      if (mouse_dav) begin
        shadow_x   <= mouse_x[PIX_W-1:0];
        shadow_y   <= mouse_y[PIX_W-1:0];
        shadow_btn <= mouse_status[2:0];
      end
      if (frame_start) begin
        active_x   <= mouse_dav ? mouse_x[PIX_W-1:0] : shadow_x;
        active_y   <= mouse_dav ? mouse_y[PIX_W-1:0] : shadow_y;
        active_btn <= mouse_dav ? mouse_status[2:0]  : shadow_btn;
      end
    end
  end

  // Single-cycle pulses on rising edges of the left and right buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_btn <= '0;
      click_l  <= 1'b0;
      click_r  <= 1'b0;
    end else begin
      click_l <= mouse_dav & mouse_status[0] & ~prev_btn[0];
      click_r <= mouse_dav & mouse_status[1] & ~prev_btn[1];
      if (mouse_dav) prev_btn <= mouse_status[1:0];
    end
  end

  // Offset from the hotspot; the top bit doubles as the borrow flag
  always_comb begin
    dx_full = {1'b0, pix_x} - {1'b0, active_x};
    dy_full = {1'b0, pix_y} - {1'b0, active_y};
    hit     = cursor_en & pix_valid &
              (dx_full[PIX_W:3] == '0) & (dy_full[PIX_W:3] == '0);
  end

  // Stage 1 register: hit decision and sprite coordinates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_bg    <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_hit   <= hit;
      s1_dx    <= dx_full[2:0];
      s1_dy    <= dy_full[2:0];
      s1_bg    <= bg_rgb;
    end
  end

  cursor_sprite_rom u_rom (
    .addr ({s1_dy, s1_dx}),
    .code (code)
  );

  // Map the sprite code to a colour, falling back to background when transparent
  always_comb begin
    pix_color = s1_bg;
    if (s1_hit) begin
      case (code)
        OUTLINE: pix_color = COLOR_W'(BLACK);
        FILL:    pix_color = COLOR_W'(WHITE);
        ACCENT:  pix_color = active_btn[0] ? CLICK_COLOR : IDLE_COLOR;
        default: pix_color = s1_bg;
      endcase
    end
  end

  // Stage 2 register: merged output, forced to zero outside active pixels
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_rgb   <= '0;
    end else begin
      out_valid <= s1_valid;
      out_rgb   <= s1_valid ? pix_color : '0;
    end
  end

endmodule
